// File: rtl/rx_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_cmd_decoder_pkg
//  Description : Opcodes, ALU operand addresses and FSM state encoding shared
//                by the UART command decoder and its timeout sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_cmd_decoder_pkg;

    localparam logic [7:0] c_CMD_WR      = 8'hAA;
    localparam logic [7:0] c_CMD_RD      = 8'hBB;
    localparam logic [7:0] c_CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] c_CMD_ALU_NOP = 8'hDD;

    localparam int unsigned c_ALU_OPA_ADDR = 0;
    localparam int unsigned c_ALU_OPB_ADDR = 1;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WR_ADDR = 3'd1;
    localparam state_t c_ST_WR_DATA = 3'd2;
    localparam state_t c_ST_RD_ADDR = 3'd3;
    localparam state_t c_ST_ALU_A   = 3'd4;
    localparam state_t c_ST_ALU_B   = 3'd5;
    localparam state_t c_ST_ALU_FUN = 3'd6;

    // States during which the ALU clock must already be running.
    function automatic logic is_alu_state(input state_t s);
        return (s == c_ST_ALU_A) || (s == c_ST_ALU_B) || (s == c_ST_ALU_FUN);
    endfunction

endpackage : rx_cmd_decoder_pkg
`default_nettype wire

// File: rtl/rx_cmd_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : rx_cmd_timeout
//  Description : Inter-byte idle counter; pulses o_expire on the cycle that
//                completes TIMEOUT_CYCLES byte-less cycles outside IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_byte_vld,
    output logic o_expire
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_expire;

    assign w_expire = i_active && !i_byte_vld &&
                      (r_count == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_expire = w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_active || i_byte_vld || w_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule : rx_cmd_timeout
`default_nettype wire

// File: rtl/rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rx_cmd_decoder
//  Description : Decodes UART byte streams into register-file write/read and
//                ALU commands. Define RX_CMD_TIMEOUT_EN to abort stalled
//                commands after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_cmd_decoder
    import rx_cmd_decoder_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  PAR_ERR,
    input  logic                  FRAME_ERR,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  CMD_DONE,
    output logic                  CMD_ERR
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr_next;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_timeout;
    logic                  w_abort;

    logic                  w_wr_en_next;
    logic                  w_rd_en_next;
    logic                  w_alu_en_next;
    logic                  w_done_next;
    logic                  w_err_next;
    logic                  w_gate_next;
    logic [ADDR_WIDTH-1:0] w_address_next;
    logic [DATA_WIDTH-1:0] w_wr_data_next;
    logic [3:0]            w_alu_fun_next;

    assign w_accept = RX_D_VLD && !PAR_ERR && !FRAME_ERR;
    assign w_reject = RX_D_VLD && (PAR_ERR || FRAME_ERR);
    assign w_abort  = w_reject || w_timeout;

`ifdef RX_CMD_TIMEOUT_EN
    rx_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (CLK),
        .rst_n      (RST),
        .i_active   (r_state != c_ST_IDLE),
        .i_byte_vld (RX_D_VLD),
        .o_expire   (w_timeout)
    );
`else
    // No timeout hardware; the parameter stays so both builds share one interface.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = c_ST_IDLE;
        end else if (w_accept) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (RX_P_DATA == DATA_WIDTH'(c_CMD_WR)) begin
                        w_state_next = c_ST_WR_ADDR;
                    end else if (RX_P_DATA == DATA_WIDTH'(c_CMD_RD)) begin
                        w_state_next = c_ST_RD_ADDR;
                    end else if (RX_P_DATA == DATA_WIDTH'(c_CMD_ALU_OP)) begin
                        w_state_next = c_ST_ALU_A;
                    end else if (RX_P_DATA == DATA_WIDTH'(c_CMD_ALU_NOP)) begin
                        w_state_next = c_ST_ALU_FUN;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
                c_ST_WR_ADDR: w_state_next = c_ST_WR_DATA;
                c_ST_ALU_A:   w_state_next = c_ST_ALU_B;
                c_ST_ALU_B:   w_state_next = c_ST_ALU_FUN;
                default:      w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered strobes and data fields
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_en_next   = 1'b0;
        w_rd_en_next   = 1'b0;
        w_alu_en_next  = 1'b0;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        w_address_next = Address;
        w_wr_data_next = WrData;
        w_alu_fun_next = ALU_FUN;
        w_wr_addr_next = r_wr_addr;

        if (w_abort) begin
            w_err_next = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_err_next = (w_state_next == c_ST_IDLE);
                end
                c_ST_WR_ADDR: begin
                    // Held internally so Address only moves with a strobe.
                    w_wr_addr_next = RX_P_DATA[ADDR_WIDTH-1:0];
                end
                c_ST_WR_DATA: begin
                    w_wr_en_next   = 1'b1;
                    w_done_next    = 1'b1;
                    w_address_next = r_wr_addr;
                    w_wr_data_next = RX_P_DATA;
                end
                c_ST_RD_ADDR: begin
                    w_rd_en_next   = 1'b1;
                    w_done_next    = 1'b1;
                    w_address_next = RX_P_DATA[ADDR_WIDTH-1:0];
                end
                c_ST_ALU_A: begin
                    w_wr_en_next   = 1'b1;
                    w_address_next = ADDR_WIDTH'(c_ALU_OPA_ADDR);
                    w_wr_data_next = RX_P_DATA;
                end
                c_ST_ALU_B: begin
                    w_wr_en_next   = 1'b1;
                    w_address_next = ADDR_WIDTH'(c_ALU_OPB_ADDR);
                    w_wr_data_next = RX_P_DATA;
                end
                c_ST_ALU_FUN: begin
                    w_alu_en_next  = 1'b1;
                    w_done_next    = 1'b1;
                    w_alu_fun_next = RX_P_DATA[3:0];
                end
                default: begin
                    w_err_next = 1'b1;
                end
            endcase
        end

        // Gate stays open through the ALU_EN cycle and closes right after it.
        w_gate_next = is_alu_state(w_state_next) || w_alu_en_next;
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            ALU_EN      <= 1'b0;
            CMD_DONE    <= 1'b0;
            CMD_ERR     <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_FUN     <= '0;
            r_wr_addr   <= '0;
        end else begin
            WrEn        <= w_wr_en_next;
            RdEn        <= w_rd_en_next;
            ALU_EN      <= w_alu_en_next;
            CMD_DONE    <= w_done_next;
            CMD_ERR     <= w_err_next;
            CLK_GATE_EN <= w_gate_next;
            Address     <= w_address_next;
            WrData      <= w_wr_data_next;
            ALU_FUN     <= w_alu_fun_next;
            r_wr_addr   <= w_wr_addr_next;
        end
    end

endmodule : rx_cmd_decoder
`default_nettype wire
